// File: rtl/bht_pkg.sv
// Shared branch-history-table types and widths used by the BHT update path.
package bht_pkg;

  localparam int BHT_IDX_W  = 10;
  localparam int BHT_HIST_W = 10;

  typedef struct packed {
    logic [BHT_IDX_W-1:0] index;
    logic                 brdir;
  } bht_upd_t;

endpackage

// File: rtl/bht_upd_fifo.sv
// Two-write / one-read update queue: storage, pointers, occupancy, and
// per-entry valid / index-compare outputs for the pending-read check.
module bht_upd_fifo
  import bht_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int IDXW  = BHT_IDX_W,
  localparam int PTRW  = $clog2(DEPTH),
  localparam int OCCW  = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_wr0_en,
  input  logic [IDXW-1:0]  i_wr0_index,
  input  logic             i_wr0_brdir,
  input  logic             i_wr1_en,
  input  logic [IDXW-1:0]  i_wr1_index,
  input  logic             i_wr1_brdir,
  input  logic             i_pop,
  input  logic [IDXW-1:0]  i_cmp_index,
  output logic [IDXW-1:0]  o_head_index,
  output logic             o_head_brdir,
  output logic [PTRW-1:0]  o_head_ptr,
  output logic [DEPTH-1:0] o_vld,
  output logic [DEPTH-1:0] o_hit,
  output logic [OCCW-1:0]  o_occ
);

  logic [IDXW-1:0]  r_index [DEPTH];
  logic [DEPTH-1:0] r_brdir;
  logic [DEPTH-1:0] r_vld;
  logic [PTRW-1:0]  r_head;
  logic [PTRW-1:0]  r_tail;
  logic [OCCW-1:0]  r_occ;
  logic [PTRW-1:0]  w_slot1;
  logic [OCCW-1:0]  w_nwr;

  // Write port 1 lands directly behind port 0 so program order is kept.
  assign w_slot1 = r_tail + PTRW'(i_wr0_en);
  assign w_nwr   = OCCW'(i_wr0_en) + OCCW'(i_wr1_en);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
      r_vld  <= '0;
    end else begin
      r_tail <= r_tail + PTRW'(w_nwr);
      r_occ  <= r_occ + w_nwr - OCCW'(i_pop);
      if (i_pop) begin
        r_head        <= r_head + PTRW'(1);
        r_vld[r_head] <= 1'b0;
      end
      if (i_wr0_en) r_vld[r_tail]  <= 1'b1;
      if (i_wr1_en) r_vld[w_slot1] <= 1'b1;
    end
  end

  // Payload carries no reset; r_vld and r_occ qualify every use of it.
  always_ff @(posedge clock) begin
    if (i_wr0_en) begin
      r_index[r_tail] <= i_wr0_index;
      r_brdir[r_tail] <= i_wr0_brdir;
    end
    if (i_wr1_en) begin
      r_index[w_slot1] <= i_wr1_index;
      r_brdir[w_slot1] <= i_wr1_brdir;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    assign o_hit[g] = (r_index[g] == i_cmp_index);
  end

  assign o_vld        = r_vld;
  assign o_head_ptr   = r_head;
  assign o_head_index = r_index[r_head];
  assign o_head_brdir = r_brdir[r_head];
  assign o_occ        = r_occ;

endmodule

// File: rtl/bht_upd_sched.sv
// BHT commit-write scheduler: buffers up to two committed branch outcomes per
// cycle and drains one per cycle onto the BHT write port.
module bht_upd_sched
  import bht_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int IDXW  = BHT_IDX_W,
  localparam int PTRW  = $clog2(DEPTH),
  localparam int OCCW  = $clog2(DEPTH + 1)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            cm0_valid_i,
  input  logic [IDXW-1:0] cm0_index_i,
  input  logic            cm0_brdir_i,
  input  logic            cm1_valid_i,
  input  logic [IDXW-1:0] cm1_index_i,
  input  logic            cm1_brdir_i,
  output logic            cm_ready_o,
  input  logic [IDXW-1:0] rd_index_i,
  output logic            rd_pending_o,
  output logic [IDXW-1:0] bht_wt_index_o,
  output logic            bht_cm_brdir_o,
  output logic            bht_cm_brdir_se_o,
  output logic [OCCW-1:0] occ_o,
  output logic            ovf_err_o
);

  logic             w_ready;
  logic             w_se;
  logic             w_acc0;
  logic             w_acc1;
  logic             w_viol;
  logic             r_ovf;
  logic [IDXW-1:0]  w_head_index;
  logic             w_head_brdir;
  logic [PTRW-1:0]  w_head_ptr;
  logic [DEPTH-1:0] w_vld;
  logic [DEPTH-1:0] w_hit;
  logic [DEPTH-1:0] w_head_oh;
  logic [OCCW-1:0]  w_occ;

  // Ready depends only on registered occupancy: room for a full pair.
  assign w_ready = (w_occ <= OCCW'(DEPTH - 2));
  assign w_se    = (w_occ != '0);
  assign w_acc0  = cm0_valid_i & w_ready;
  assign w_acc1  = cm1_valid_i & w_ready;
  assign w_viol  = (cm0_valid_i | cm1_valid_i) & ~w_ready;

  bht_upd_fifo #(
    .DEPTH (DEPTH),
    .IDXW  (IDXW)
  ) u_fifo (
    .clock        (clock),
    .reset_n      (reset_n),
    .i_wr0_en     (w_acc0 | w_acc1),
    .i_wr0_index  (cm0_valid_i ? cm0_index_i : cm1_index_i),
    .i_wr0_brdir  (cm0_valid_i ? cm0_brdir_i : cm1_brdir_i),
    .i_wr1_en     (w_acc0 & w_acc1),
    .i_wr1_index  (cm1_index_i),
    .i_wr1_brdir  (cm1_brdir_i),
    .i_pop        (w_se),
    .i_cmp_index  (rd_index_i),
    .o_head_index (w_head_index),
    .o_head_brdir (w_head_brdir),
    .o_head_ptr   (w_head_ptr),
    .o_vld        (w_vld),
    .o_hit        (w_hit),
    .o_occ        (w_occ)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    r_ovf <= 1'b0;
    else if (w_viol) r_ovf <= 1'b1;
  end

  // The head is being written this cycle and the BHT bypasses it itself.
  always_comb begin
    w_head_oh             = '0;
    w_head_oh[w_head_ptr] = 1'b1;
  end

  assign rd_pending_o      = |(w_vld & w_hit & ~w_head_oh);
  assign bht_cm_brdir_se_o = w_se;
  assign bht_wt_index_o    = w_se ? w_head_index : '0;
  assign bht_cm_brdir_o    = w_se & w_head_brdir;
  assign cm_ready_o        = w_ready;
  assign occ_o             = w_occ;
  assign ovf_err_o         = r_ovf;

endmodule
